// File: rtl/qspi_host_pkg.sv
// Shared types and constants for the single/quad SPI host frame engine.
package qspi_host_pkg;

    typedef enum logic [2:0] {
        StIdle, StCmd, StAddr, StDummy, StWdata, StRdata, StEnd, StGap
    } state_e;

    localparam logic [1:0] SPI_STD     = 2'b00;
    localparam logic [1:0] SPI_QUAD_TX = 2'b01;
    localparam logic [1:0] SPI_QUAD_RX = 2'b10;

    localparam logic [7:0] CMD_WRITE_MEM  = 8'h02;
    localparam logic [7:0] CMD_READ_MEM   = 8'h0B;
    localparam logic [7:0] CMD_WRITE_REG1 = 8'h11;
    localparam logic [7:0] CMD_READ_REG0  = 8'h05;

    // Output lines for the leading bits of a shift word; sdo3 carries the nibble MSB.
    function automatic logic [3:0] tx_lines(logic [31:0] word, logic quad);
        return quad ? word[31:28] : {3'b000, word[31]};
    endfunction

endpackage

// File: rtl/qspi_host_ctrl_sck_gen.sv
// SPI mode-0 clock generator: sck toggles every CLK_DIV enabled clocks and idles low.
module qspi_sck_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    output logic sck_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int unsigned    CntW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

    logic [CntW-1:0] cnt_q;
    logic            sck_q;
    logic            tick;

    // rise/fall flag the clk edge on which sck is about to change
    assign tick   = en_i && (cnt_q == CntMax);
    assign rise_o = tick && !sck_q;
    assign fall_o = tick && sck_q;
    assign sck_o  = sck_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else if (!en_i) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else if (tick) begin
            cnt_q <= '0;
            sck_q <= ~sck_q;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

endmodule

// File: rtl/qspi_host_ctrl.sv
// Single/quad SPI master frame engine: cmd, optional address, optional dummy, 32-bit data.
module qspi_host_ctrl
    import qspi_host_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned CS_GAP  = 2,
    parameter int unsigned DUMMY_W = 6
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [7:0]         req_cmd_i,
    input  logic               req_has_addr_i,
    input  logic [31:0]        req_addr_i,
    input  logic               req_write_i,
    input  logic [31:0]        req_wdata_i,
    input  logic               req_quad_i,
    input  logic [DUMMY_W-1:0] req_dummy_i,
    output logic               rsp_valid_o,
    output logic [31:0]        rsp_rdata_o,
    output logic               spi_sck_o,
    output logic               spi_csn_o,
    output logic [1:0]         spi_mode_o,
    output logic               spi_sdo0_o,
    output logic               spi_sdo1_o,
    output logic               spi_sdo2_o,
    output logic               spi_sdo3_o,
    input  logic               spi_sdi0_i,
    input  logic               spi_sdi1_i,
    input  logic               spi_sdi2_i,
    input  logic               spi_sdi3_i
);
    localparam int unsigned BitsW = (DUMMY_W > 6) ? DUMMY_W : 6;
    localparam int unsigned WaitW = $clog2(CS_GAP * CLK_DIV + 1);

    state_e             state_q, nxt_st, data_st;
    logic               ready_q, rsp_valid_q, csn_q;
    logic               quad_q, write_q, has_addr_q;
    logic [31:0]        addr_q, wdata_q, sr_q, rdata_q, sr_sh, sr_in;
    logic [DUMMY_W-1:0] dummy_q;
    logic [BitsW-1:0]   bits_q, data_bits;
    logic [WaitW-1:0]   wait_q;
    logic [1:0]         mode_q, rx_mode;
    logic [3:0]         sdo_q;
    logic               sck_en, sck_rise, sck_fall;

    assign sck_en = state_q inside {StCmd, StAddr, StDummy, StWdata, StRdata};

    qspi_sck_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sck_gen (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (sck_en),
        .sck_o (spi_sck_o),
        .rise_o(sck_rise),
        .fall_o(sck_fall)
    );

    assign data_bits = quad_q ? BitsW'(8) : BitsW'(32);
    assign rx_mode   = quad_q ? SPI_QUAD_RX : SPI_STD;
    assign sr_sh     = quad_q ? {sr_q[27:0], 4'h0} : {sr_q[30:0], 1'b0};
    assign sr_in     = quad_q ? {sr_q[27:0], spi_sdi3_i, spi_sdi2_i, spi_sdi1_i, spi_sdi0_i}
                              : {sr_q[30:0], spi_sdi0_i};

    always_comb begin
        data_st = StRdata;
        if (write_q) begin
            data_st = StWdata;
        end else if (dummy_q != '0) begin
            data_st = StDummy;
        end
        nxt_st = StEnd;
        unique case (state_q)
            StCmd:   nxt_st = has_addr_q ? StAddr : data_st;
            StAddr:  nxt_st = data_st;
            StDummy: nxt_st = StRdata;
            default: nxt_st = StEnd;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            csn_q       <= 1'b1;
            mode_q      <= SPI_STD;
            sdo_q       <= '0;
            sr_q        <= '0;
            bits_q      <= '0;
            wait_q      <= '0;
            quad_q      <= 1'b0;
            write_q     <= 1'b0;
            has_addr_q  <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            dummy_q     <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (!ready_q) begin
                        ready_q <= 1'b1;
                    end else if (req_valid_i) begin
                        ready_q    <= 1'b0;
                        csn_q      <= 1'b0;
                        state_q    <= StCmd;
                        quad_q     <= req_quad_i;
                        write_q    <= req_write_i;
                        has_addr_q <= req_has_addr_i;
                        addr_q     <= req_addr_i;
                        wdata_q    <= req_wdata_i;
                        dummy_q    <= req_dummy_i;
                        mode_q     <= req_quad_i ? SPI_QUAD_TX : SPI_STD;
                        sr_q       <= {req_cmd_i, 24'h0};
                        sdo_q      <= tx_lines({req_cmd_i, 24'h0}, req_quad_i);
                        bits_q     <= req_quad_i ? BitsW'(2) : BitsW'(8);
                    end
                end
                StCmd, StAddr, StDummy, StWdata, StRdata: begin
                    if (sck_rise && state_q == StRdata) begin
                        sr_q <= sr_in;
                    end
                    // Phase changes ride on the last falling edge of the current phase
                    if (sck_fall) begin
                        if (bits_q == BitsW'(1)) begin
                            state_q <= nxt_st;
                            unique case (nxt_st)
                                StAddr: begin
                                    sr_q   <= addr_q;
                                    sdo_q  <= tx_lines(addr_q, quad_q);
                                    bits_q <= data_bits;
                                end
                                StWdata: begin
                                    sr_q   <= wdata_q;
                                    sdo_q  <= tx_lines(wdata_q, quad_q);
                                    bits_q <= data_bits;
                                end
                                StDummy: begin
                                    sr_q   <= '0;
                                    sdo_q  <= '0;
                                    bits_q <= BitsW'(dummy_q);
                                    mode_q <= rx_mode;
                                end
                                StRdata: begin
                                    sr_q   <= '0;
                                    sdo_q  <= '0;
                                    bits_q <= data_bits;
                                    mode_q <= rx_mode;
                                end
                                default: begin
                                    sdo_q  <= '0;
                                    wait_q <= WaitW'(CLK_DIV - 1);
                                end
                            endcase
                        end else begin
                            bits_q <= bits_q - BitsW'(1);
                            if (state_q inside {StCmd, StAddr, StWdata}) begin
                                sr_q  <= sr_sh;
                                sdo_q <= tx_lines(sr_sh, quad_q);
                            end
                        end
                    end
                end
                StEnd: begin
                    if (wait_q == '0) begin
                        csn_q       <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        if (!write_q) begin
                            rdata_q <= sr_q;
                        end
                        sr_q    <= '0;
                        mode_q  <= SPI_STD;
                        wait_q  <= WaitW'(CS_GAP * CLK_DIV - 1);
                        state_q <= StGap;
                    end else begin
                        wait_q <= wait_q - WaitW'(1);
                    end
                end
                StGap: begin
                    if (wait_q == '0) begin
                        ready_q <= 1'b1;
                        state_q <= StIdle;
                    end else begin
                        wait_q <= wait_q - WaitW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rdata_q;
    assign spi_csn_o   = csn_q;
    assign spi_mode_o  = mode_q;
    assign spi_sdo0_o  = sdo_q[0];
    assign spi_sdo1_o  = sdo_q[1];
    assign spi_sdo2_o  = sdo_q[2];
    assign spi_sdo3_o  = sdo_q[3];

endmodule

// File: tb/tb_qspi_host_ctrl.sv
// Bench for qspi_host_ctrl: directed and random frames against a pin-level slave/reference model.
module tb_qspi_host_ctrl;
    import qspi_host_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        sel;
    logic        req_valid, req_has_addr, req_write, req_quad;
    logic [7:0]  req_cmd;
    logic [31:0] req_addr, req_wdata;
    logic [5:0]  req_dummy;
    logic [3:0]  sdi;

    logic [1:0]        rdy, rsp, sck, csn;
    logic [1:0][31:0]  rdata;
    logic [1:0][1:0]   mode;
    logic [1:0][3:0]   sdo;

    logic        o_rdy, o_rsp, o_sck, o_csn;
    logic [31:0] o_rdata;
    logic [1:0]  o_mode;
    logic [3:0]  o_sdo;
    assign o_rdy   = rdy[sel];
    assign o_rsp   = rsp[sel];
    assign o_sck   = sck[sel];
    assign o_csn   = csn[sel];
    assign o_rdata = rdata[sel];
    assign o_mode  = mode[sel];
    assign o_sdo   = sdo[sel];

    qspi_host_ctrl #(.CLK_DIV(4), .CS_GAP(2), .DUMMY_W(6)) u_dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid & ~sel), .req_ready_o(rdy[0]),
        .req_cmd_i(req_cmd), .req_has_addr_i(req_has_addr), .req_addr_i(req_addr),
        .req_write_i(req_write), .req_wdata_i(req_wdata), .req_quad_i(req_quad),
        .req_dummy_i(req_dummy), .rsp_valid_o(rsp[0]), .rsp_rdata_o(rdata[0]),
        .spi_sck_o(sck[0]), .spi_csn_o(csn[0]), .spi_mode_o(mode[0]),
        .spi_sdo0_o(sdo[0][0]), .spi_sdo1_o(sdo[0][1]), .spi_sdo2_o(sdo[0][2]),
        .spi_sdo3_o(sdo[0][3]), .spi_sdi0_i(sdi[0]), .spi_sdi1_i(sdi[1]),
        .spi_sdi2_i(sdi[2]), .spi_sdi3_i(sdi[3])
    );

    qspi_host_ctrl #(.CLK_DIV(1), .CS_GAP(2), .DUMMY_W(6)) u_dut_div1 (
        .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid & sel), .req_ready_o(rdy[1]),
        .req_cmd_i(req_cmd), .req_has_addr_i(req_has_addr), .req_addr_i(req_addr),
        .req_write_i(req_write), .req_wdata_i(req_wdata), .req_quad_i(req_quad),
        .req_dummy_i(req_dummy), .rsp_valid_o(rsp[1]), .rsp_rdata_o(rdata[1]),
        .spi_sck_o(sck[1]), .spi_csn_o(csn[1]), .spi_mode_o(mode[1]),
        .spi_sdo0_o(sdo[1][0]), .spi_sdo1_o(sdo[1][1]), .spi_sdo2_o(sdo[1][2]),
        .spi_sdo3_o(sdo[1][3]), .spi_sdi0_i(sdi[0]), .spi_sdi1_i(sdi[1]),
        .spi_sdi2_i(sdi[2]), .spi_sdi3_i(sdi[3])
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int               n_checks, n_errs;
    int               prev_up_cyc;
    logic             chk_gap;
    logic [1:0][31:0] exp_rd;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic scramble_req();
        req_cmd      = 8'($urandom);
        req_has_addr = 1'($urandom);
        req_addr     = $urandom;
        req_write    = 1'($urandom);
        req_wdata    = $urandom;
        req_quad     = 1'($urandom);
        req_dummy    = 6'($urandom);
    endtask

    // Drive one request and play the slave; timing and pin values come from the frame rules.
    task automatic run_txn(input logic keep_valid, input logic [7:0] cmd, input logic has_addr,
                           input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                           input logic quad, input logic [5:0] dummy, input logic [31:0] sdata);
        int div, g, cmdc, addrc, datac, txn, tot, hdr, k;
        int rises, start_cyc, fall_cyc, first_rise, last_fall, up_cyc, rdy_cyc;
        int rsp_cnt, rdy_bad, sdo_bad, mode_bad;
        logic accepted, done, prev_sck, start_rdy, rsp_at_up;
        logic [71:0] txv;
        logic [3:0]  e;
        logic [1:0]  em;
        div   = sel ? 1 : 4;
        g     = 2 * div;
        cmdc  = quad ? 2 : 8;
        addrc = has_addr ? (quad ? 8 : 32) : 0;
        datac = quad ? 8 : 32;
        txn   = cmdc + addrc + (wr ? datac : 0);
        hdr   = cmdc + addrc + (wr ? 0 : int'(dummy));
        tot   = wr ? txn : hdr + datac;
        txv   = {cmd, 64'h0};
        if (has_addr) begin
            txv[63:32] = addr;
            if (wr) txv[31:0] = wdata;
        end else if (wr) begin
            txv[63:32] = wdata;
        end
        req_cmd = cmd; req_has_addr = has_addr; req_addr = addr; req_write = wr;
        req_wdata = wdata; req_quad = quad; req_dummy = dummy; req_valid = 1'b1;
        start_rdy = o_rdy; start_cyc = cyc;
        accepted = 1'b0; done = 1'b0; prev_sck = 1'b0; rsp_at_up = 1'b0;
        rises = 0; fall_cyc = 0; first_rise = 0; last_fall = 0; up_cyc = -1; rdy_cyc = 0;
        rsp_cnt = 0; rdy_bad = 0; sdo_bad = 0; mode_bad = 0;
        for (int t = 0; t < 6000 && !done; t++) begin
            @(posedge clk);
            #1;
            if (!accepted) begin
                if (!o_csn) begin
                    accepted = 1'b1;
                    fall_cyc = cyc;
                    if (start_rdy) check_eq("accept_to_csn", 64'(fall_cyc - start_cyc), 64'(1));
                    if (chk_gap) check_eq("b2b_csn_gap", 64'(fall_cyc - prev_up_cyc), 64'(g + 1));
                    if (!keep_valid) req_valid = 1'b0;
                    scramble_req();
                end
            end else if (up_cyc < 0) begin
                if (o_rdy) rdy_bad++;
                if (o_rsp) rsp_cnt++;
                if (o_sck && !prev_sck) begin
                    if (rises < txn) begin
                        e  = quad ? 4'(txv >> (68 - 4 * rises)) : {3'b000, txv[71 - rises]};
                        em = quad ? SPI_QUAD_TX : SPI_STD;
                        if (o_sdo !== e) sdo_bad++;
                    end else begin
                        em = quad ? SPI_QUAD_RX : SPI_STD;
                        if (!wr && rises < hdr && o_sdo !== 4'h0) sdo_bad++;
                    end
                    if (o_mode !== em) mode_bad++;
                    if (rises == 0) first_rise = cyc;
                    rises++;
                end
                if (!o_sck && prev_sck) begin
                    last_fall = cyc;
                    k   = rises - hdr;
                    sdi = 4'($urandom);
                    if (!wr && k >= 0 && k < datac) begin
                        if (quad) sdi = 4'(sdata >> (28 - 4 * k));
                        else sdi[0] = sdata[31 - k];
                    end
                end
                prev_sck = o_sck;
                if (o_csn) begin
                    up_cyc    = cyc;
                    rsp_at_up = o_rsp;
                    check_eq("sck_idle_at_csn_rise", 64'(o_sck), 64'(0));
                end
            end else begin
                if (o_rsp) rsp_cnt++;
                if (o_rdy) begin
                    rdy_cyc = cyc;
                    done    = 1'b1;
                end
            end
        end
        check_eq("frame_done", 64'(done), 64'(1));
        check_eq("sck_cycles", 64'(rises), 64'(tot));
        check_eq("first_sck_rise", 64'(first_rise - fall_cyc), 64'(div));
        check_eq("end_wait", 64'(up_cyc - last_fall), 64'(div));
        check_eq("rsp_with_csn", 64'(rsp_at_up), 64'(1));
        check_eq("rsp_count", 64'(rsp_cnt), 64'(1));
        check_eq("ready_in_frame", 64'(rdy_bad), 64'(0));
        check_eq("gap_to_ready", 64'(rdy_cyc - up_cyc), 64'(g));
        check_eq("sdo_stream", 64'(sdo_bad), 64'(0));
        check_eq("spi_mode", 64'(mode_bad), 64'(0));
        if (!wr) exp_rd[sel] = sdata;
        check_eq("rsp_rdata", 64'(o_rdata), 64'(exp_rd[sel]));
        prev_up_cyc = up_cyc;
    endtask

    task automatic random_txn();
        run_txn(1'b0, 8'($urandom), 1'($urandom), $urandom, 1'($urandom), $urandom,
                1'($urandom), 6'($urandom_range(0, 7)), $urandom);
    endtask

    task automatic check_reset_pins(input string tag);
        check_eq({tag, "_csn"}, 64'(o_csn), 64'(1));
        check_eq({tag, "_sck"}, 64'(o_sck), 64'(0));
        check_eq({tag, "_sdo"}, 64'(o_sdo), 64'(0));
        check_eq({tag, "_rsp"}, 64'(o_rsp), 64'(0));
        check_eq({tag, "_rdy"}, 64'(o_rdy), 64'(0));
        check_eq({tag, "_mode"}, 64'(o_mode), 64'(SPI_STD));
    endtask

    initial begin
        int   r5, rsp_seen;
        logic p5;
        n_checks = 0; n_errs = 0; sel = 1'b0; req_valid = 1'b0; chk_gap = 1'b0;
        prev_up_cyc = 0; sdi = '0; exp_rd = '0;
        scramble_req();
        repeat (3) @(posedge clk);
        #1;
        check_reset_pins("reset");
        check_eq("reset_rdata", 64'(o_rdata), 64'(0));
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("ready_after_reset", 64'(o_rdy), 64'(1));

        run_txn(1'b0, CMD_WRITE_MEM, 1'b1, 32'h0000_1000, 1'b1, 32'hDEAD_BEEF, 1'b0, 6'd0,
                32'h0);
        run_txn(1'b0, CMD_READ_MEM, 1'b1, 32'h0000_2000, 1'b0, 32'h0, 1'b1, 6'd32,
                32'h1234_5678);
        run_txn(1'b0, CMD_WRITE_REG1, 1'b0, 32'h0, 1'b1, 32'h0000_0001, 1'b1, 6'd0, 32'h0);

        run_txn(1'b1, CMD_WRITE_MEM, 1'b1, $urandom, 1'b1, $urandom, 1'b0, 6'd0, 32'h0);
        chk_gap = 1'b1;
        run_txn(1'b0, CMD_WRITE_MEM, 1'b1, $urandom, 1'b1, $urandom, 1'b1, 6'd0, 32'h0);
        chk_gap = 1'b0;

        // Reset in the middle of the address phase
        req_cmd = CMD_WRITE_MEM; req_has_addr = 1'b1; req_addr = $urandom; req_write = 1'b1;
        req_wdata = $urandom; req_quad = 1'b0; req_dummy = '0; req_valid = 1'b1;
        r5 = 0; p5 = 1'b0;
        for (int t = 0; t < 2000 && r5 < 10; t++) begin
            @(posedge clk);
            #1;
            if (!o_csn) req_valid = 1'b0;
            if (o_sck && !p5) r5++;
            p5 = o_sck;
        end
        check_eq("reached_addr_phase", 64'(r5), 64'(10));
        #2 rst = 1'b1;
        #1;
        check_reset_pins("midframe_reset");
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        exp_rd = '0;
        rsp_seen = 0;
        for (int t = 0; t < 4; t++) begin
            @(posedge clk);
            #1;
            if (o_rsp) rsp_seen++;
            if (t == 0) check_eq("ready_after_midframe_reset", 64'(o_rdy), 64'(1));
        end
        check_eq("no_rsp_after_abort", 64'(rsp_seen), 64'(0));
        run_txn(1'b0, CMD_WRITE_MEM, 1'b1, $urandom, 1'b1, $urandom, 1'b0, 6'd0, 32'h0);

        for (int i = 0; i < 12; i++) random_txn();

        sel = 1'b1;
        run_txn(1'b0, CMD_READ_REG0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 6'd0, $urandom);
        run_txn(1'b0, CMD_READ_MEM, 1'b1, $urandom, 1'b0, 32'h0, 1'b0, 6'd0, $urandom);
        for (int i = 0; i < 8; i++) random_txn();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
